// File: rtl/trigger_pkg.sv
// Shared constants for the trigger status readback block.
// Holds the register map addresses, the word returned by a pop from an empty
// FIFO, the FSTAT bit positions and a helper that packs the FSTAT word.
package trigger_pkg;

    // Register map of the readback bus (4-bit address space)
    typedef enum logic [3:0] {
        REG_FLAGS   = 4'd0,
        REG_TRIGCNT = 4'd1,
        REG_FSTAT   = 4'd2,
        REG_FPOP    = 4'd3,
        REG_TSNOW   = 4'd4
    } reg_addr_e;

    localparam logic [3:0]  ADDR_FLAGS   = 4'd0;
    localparam logic [3:0]  ADDR_TRIGCNT = 4'd1;
    localparam logic [3:0]  ADDR_FSTAT   = 4'd2;
    localparam logic [3:0]  ADDR_FPOP    = 4'd3;
    localparam logic [3:0]  ADDR_TSNOW   = 4'd4;

    localparam logic [31:0] FIFO_EMPTY_WORD = 32'hFFFF_FFFF;

    localparam int FSTAT_EMPTY_BIT = 16;
    localparam int FSTAT_FULL_BIT  = 17;
    localparam int FSTAT_OVF_BIT   = 18;

    // Builds the FSTAT word: fill level in the low bits, status flags above
    function automatic logic [31:0] pack_fstat(input logic [15:0] level,
                                               input logic        is_empty,
                                               input logic        is_full,
                                               input logic        ovf);
        logic [31:0] word;
        word                  = 32'd0;
        word[15:0]            = level;
        word[FSTAT_EMPTY_BIT] = is_empty;
        word[FSTAT_FULL_BIT]  = is_full;
        word[FSTAT_OVF_BIT]   = ovf;
        return word;
    endfunction

endpackage

// File: rtl/trigger_ts_fifo.sv
// Synchronous timestamp FIFO, width DW, depth 2**AW.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and data
//   pop          : read request (head is presented combinationally)
//   head         : oldest stored entry (undefined when empty)
//   level        : fill level 0..2**AW
//   full, empty  : status
//   dropped      : push lost this cycle because the FIFO stayed full
// A pop is evaluated before a push, so a full FIFO popped and pushed in the
// same cycle accepts the new entry and keeps its level.
module trigger_ts_fifo #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          dropped
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign full      = (level_r == (AW+1)'(DEPTH));
    assign empty     = (level_r == (AW+1)'(0));
    assign level     = level_r;
    assign head      = mem_r[rd_ptr_r];
    // The pop frees a slot first, which lets a push into a full FIFO succeed
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign dropped   = push & ~push_ok_s;

    // Pointer and fill-level bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/trigger_status_interface.sv
// CPU readback side of the trigger register bank.
// Captures sync-qualified events into sticky flags, counts triggers, and
// stores the timestamp of each trigger in a FIFO. The CPU reads everything
// over a 4-bit address / 32-bit data bus with a fixed 1-clk read latency.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   sync           : trigger-domain clock enable, qualifies all capture
//   evt_in         : event lines, sampled when sync=1
//   trig           : trigger strobe, sampled when sync=1
//   read, address  : bus read request and register address
//   readdata       : read data, held until the next read
//   readdatavalid  : one-clk strobe one cycle after each accepted read
module trigger_status_interface
    import trigger_pkg::*;
#(
    parameter int NEVT    = 8,
    parameter int FIFO_AW = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sync,
    input  logic [NEVT-1:0] evt_in,
    input  logic            trig,
    input  logic            read,
    input  logic [3:0]      address,
    output logic [31:0]     readdata,
    output logic            readdatavalid
);

    logic [31:0]     ts_r;
    logic [31:0]     trigcnt_r;
    logic [NEVT-1:0] flags_r;
    logic            ovf_r;

    logic            push_s;
    logic            rd_flags_s;
    logic            rd_fstat_s;
    logic            rd_fpop_s;
    logic [NEVT-1:0] evt_new_s;
    logic [NEVT-1:0] flags_clr_s;
    logic [31:0]     flags_word_s;
    logic [31:0]     rdata_s;

    logic [31:0]     fifo_head_s;
    logic [FIFO_AW:0] fifo_level_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            fifo_drop_s;

    assign push_s     = sync & trig;
    assign rd_flags_s = read & (address == ADDR_FLAGS);
    assign rd_fstat_s = read & (address == ADDR_FSTAT);
    assign rd_fpop_s  = read & (address == ADDR_FPOP);

    trigger_ts_fifo #(
        .AW (FIFO_AW),
        .DW (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (rd_fpop_s),
        .din     (ts_r),
        .head    (fifo_head_s),
        .level   (fifo_level_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .dropped (fifo_drop_s)
    );

    // Event qualification and the set of flag bits returned by this read
    always_comb begin
        evt_new_s    = '0;
        flags_clr_s  = '0;
        flags_word_s = 32'd0;
        if (sync) begin
            evt_new_s = evt_in;
        end else begin
            evt_new_s = '0;
        end
        if (rd_flags_s) begin
            flags_clr_s = flags_r;
        end else begin
            flags_clr_s = '0;
        end
        flags_word_s[NEVT-1:0] = flags_r;
    end

    // Read data mux; an empty FPOP returns the marker word instead of stale memory
    always_comb begin
        rdata_s = 32'd0;
        case (address)
            ADDR_FLAGS:   rdata_s = flags_word_s;
            ADDR_TRIGCNT: rdata_s = trigcnt_r;
            ADDR_FSTAT:   rdata_s = pack_fstat(16'(fifo_level_s), fifo_empty_s,
                                               fifo_full_s, ovf_r);
            ADDR_FPOP: begin
                if (fifo_empty_s) begin
                    rdata_s = FIFO_EMPTY_WORD;
                end else begin
                    rdata_s = fifo_head_s;
                end
            end
            ADDR_TSNOW:   rdata_s = ts_r;
            default:      rdata_s = 32'd0;
        endcase
    end

    // Timestamp, trigger counter, sticky flags and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_r      <= 32'd0;
            trigcnt_r <= 32'd0;
            flags_r   <= '0;
            ovf_r     <= 1'b0;
        end else begin
            if (sync) begin
                ts_r <= ts_r + 32'd1;
            end
            if (push_s) begin
                trigcnt_r <= trigcnt_r + 32'd1;
            end
            // Only the bits actually returned are cleared; a same-cycle event survives
            flags_r <= (flags_r & ~flags_clr_s) | evt_new_s;
            // A new overflow in the read cycle wins over the clear
            ovf_r   <= (ovf_r & ~rd_fstat_s) | fifo_drop_s;
        end
    end

    // Registered bus response; data is held between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= 32'd0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rdata_s;
            end
        end
    end

endmodule

// File: tb/tb_trigger_status_interface.sv
// Self-checking bench for trigger_status_interface: directed scenarios plus
// randomized traffic, compared against a queue-based reference model.
module tb_trigger_status_interface;

    logic        clk;
    logic        reset_n;
    logic        sync;
    logic [7:0]  evt_in;
    logic        trig;
    logic        read;
    logic [3:0]  address;
    logic [31:0] readdata;
    logic        readdatavalid;

    int errs;
    int checks;

    // reference model state
    logic [31:0] m_ts;
    logic [31:0] m_trigcnt;
    logic [7:0]  m_flags;
    logic        m_ovf;
    logic [31:0] m_q[$];
    logic [31:0] m_last;

    trigger_status_interface #(.NEVT(8), .FIFO_AW(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sync          (sync),
        .evt_in        (evt_in),
        .trig          (trig),
        .read          (read),
        .address       (address),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_ts      = 32'd0;
        m_trigcnt = 32'd0;
        m_flags   = 8'd0;
        m_ovf     = 1'b0;
        m_q.delete();
        m_last    = 32'd0;
    endtask

    // one bus cycle: drive, predict, clock, check
    task automatic step(input logic s, input logic [7:0] e, input logic t,
                        input logic r, input logic [3:0] a);
        logic [31:0] exp;
        logic        new_ovf;
        logic [31:0] junk;
        sync = s; evt_in = e; trig = t; read = r; address = a;
        exp = 32'd0;
        new_ovf = 1'b0;
        if (r) begin
            case (a)
                4'd0: exp = {24'd0, m_flags};
                4'd1: exp = m_trigcnt;
                4'd2: begin
                    exp = 32'(m_q.size());
                    if (m_q.size() == 0)  exp = exp | 32'h0001_0000;
                    if (m_q.size() == 16) exp = exp | 32'h0002_0000;
                    if (m_ovf)            exp = exp | 32'h0004_0000;
                end
                4'd3: exp = (m_q.size() > 0) ? m_q[0] : 32'hFFFF_FFFF;
                4'd4: exp = m_ts;
                default: exp = 32'd0;
            endcase
        end
        // state update at the closing edge
        if (r && a == 4'd0) m_flags = m_flags & ~exp[7:0];
        if (s) m_flags = m_flags | e;
        if (r && a == 4'd3 && m_q.size() > 0) junk = m_q.pop_front();
        if (s && t) begin
            m_trigcnt = m_trigcnt + 32'd1;
            if (m_q.size() < 16) m_q.push_back(m_ts);
            else new_ovf = 1'b1;
        end
        if (r && a == 4'd2) m_ovf = new_ovf;
        else m_ovf = m_ovf | new_ovf;
        if (s) m_ts = m_ts + 32'd1;
        if (r) m_last = exp;

        @(posedge clk);
        #1;
        check_eq("rdvalid", 32'(readdatavalid), 32'(r));
        if (r) check_eq($sformatf("read_addr%0d", a), readdata, exp);
        else   check_eq("hold", readdata, m_last);
    endtask

    // reset asserted while a read is pending; that read must never complete
    task automatic do_reset();
        read = 1'b1; address = 4'd1; sync = 1'b1; trig = 1'b1;
        #2;
        reset_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check_eq("rst_rdata", readdata, 32'd0);
        check_eq("rst_rdvalid", 32'(readdatavalid), 32'd0);
        @(posedge clk);
        #1;
        read = 1'b0; sync = 1'b0; trig = 1'b0;
        reset_n = 1'b1;
        step(1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        errs = 0; checks = 0;
        reset_n = 1'b0; sync = 1'b0; evt_in = 8'd0; trig = 1'b0;
        read = 1'b0; address = 4'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, 8'h3C, 1'b1, 1'b0, 4'd0);
        step(1'b1, 8'h00, 1'b1, 1'b0, 4'd0);

        // reset mid-traffic, then every register
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 4'(i));
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd2);
        check_eq("fstat_after_reset", readdata, 32'h0001_0000);

        // sticky flags
        step(1'b1, 8'h05, 1'b0, 1'b0, 4'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        check_eq("flags_first", readdata, 32'h05);
        step(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        check_eq("flags_cleared", readdata, 32'h00);
        step(1'b1, 8'h05, 1'b0, 1'b0, 4'd0);
        step(1'b1, 8'h02, 1'b0, 1'b1, 4'd0);
        check_eq("flags_race_1", readdata, 32'h05);
        step(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        check_eq("flags_race_2", readdata, 32'h02);

        // FIFO ordering with triggers at timestamps 10, 20, 30
        do_reset();
        while (m_ts <= 32'd30)
            step(1'b1, 8'd0, (m_ts == 32'd10 || m_ts == 32'd20 || m_ts == 32'd30), 1'b0, 4'd0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd2);
        check_eq("fstat_level3", readdata, 32'h3);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd3);
        check_eq("fpop_10", readdata, 32'd10);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd3);
        check_eq("fpop_20", readdata, 32'd20);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd3);
        check_eq("fpop_30", readdata, 32'd30);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd3);
        check_eq("fpop_empty", readdata, 32'hFFFF_FFFF);

        // overflow
        do_reset();
        repeat (17) step(1'b1, 8'd0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd2);
        check_eq("fstat_ovf", readdata, 32'h0006_0010);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd1);
        check_eq("trigcnt_17", readdata, 32'd17);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd2);
        check_eq("fstat_ovf_cleared", readdata, 32'h0002_0010);

        // collision on a full FIFO: pop then push, newest stored
        step(1'b1, 8'd0, 1'b1, 1'b1, 4'd3);
        check_eq("collide_pop", readdata, 32'd0);
        step(1'b0, 8'd0, 1'b0, 1'b1, 4'd2);
        check_eq("collide_fstat", readdata, 32'h0002_0010);
        repeat (16) step(1'b0, 8'd0, 1'b0, 1'b1, 4'd3);
        check_eq("collide_newest", readdata, 32'd17);

        // back-to-back reads with sync=0: nothing moves
        step(1'b0, 8'hFF, 1'b1, 1'b1, 4'd4);
        step(1'b0, 8'hFF, 1'b1, 1'b1, 4'd4);
        step(1'b0, 8'hFF, 1'b1, 1'b1, 4'd1);
        step(1'b0, 8'hFF, 1'b1, 1'b1, 4'd0);
        check_eq("b2b_flags", readdata, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ra;
            if ($urandom_range(0, 399) == 0) do_reset();
            if ($urandom_range(0, 5) == 0) ra = 4'($urandom_range(5, 15));
            else ra = 4'($urandom_range(0, 4));
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, ra);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
